// File: rtl/frame_decoder.sv
// Byte-stream frame decoder: sync hunt, N_CTRL-byte header into a control bank, ACK, then sample assembly.
// Optional header XOR checksum with NACK when FRAME_DECODER_CHECKSUM_EN is defined.
module frame_decoder #(
    parameter int          N_CTRL       = 2,
    parameter int          SAMPLE_BYTES = 2,
    parameter logic [7:0]  SYNC_WORD    = 8'hFF,
    parameter logic [7:0]  ACK_WORD     = 8'hAA,
    parameter logic [7:0]  NACK_WORD    = 8'h55,
    parameter int          TIMEOUT      = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                data_rx,
    input  logic                      rx,
    output logic [7:0]                data_tx,
    output logic                      tx,
    output logic [8*N_CTRL-1:0]       ctrl,
    output logic                      ctrl_valid,
    output logic [8*SAMPLE_BYTES-1:0] sample,
    output logic                      sample_valid,
    output logic                      in_stream
);

    localparam int BC_W = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
    localparam int SC_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam int TC_W = $clog2(TIMEOUT);
    localparam int SW   = 8 * SAMPLE_BYTES;

    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(N_CTRL - 1);
    localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SAMPLE_BYTES - 1);
    localparam logic [TC_W-1:0] TMO_LAST = TC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTRL,
`ifdef FRAME_DECODER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_CHECK,
        ST_ACK,
        ST_STREAM
    } state_t;

    state_t                state_q, state_d;
    logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [TC_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [SC_W-1:0]       smp_cnt_q, smp_cnt_d;
    logic [8*N_CTRL-1:0]   shadow_q, shadow_d;
    logic [SW-1:0]         asm_q, asm_d;
    logic [7:0]            data_tx_q, data_tx_d;
    logic                  tx_q, tx_d;
    logic [8*N_CTRL-1:0]   ctrl_q, ctrl_d;
    logic                  ctrl_valid_q, ctrl_valid_d;
    logic [SW-1:0]         sample_q, sample_d;
    logic                  sample_valid_q, sample_valid_d;
    logic [SW+7:0]         asm_shift;

    // First byte of a sample ends up most significant once all bytes are shifted in.
    assign asm_shift = {asm_q, data_rx};

`ifdef FRAME_DECODER_CHECKSUM_EN
    logic       csum_bad_q, csum_bad_d;
    logic [7:0] csum_exp;

    always_comb begin
        csum_exp = 8'h00;
        for (int k = 0; k < N_CTRL; k++) begin
            csum_exp = csum_exp ^ shadow_q[8*k +: 8];
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        smp_cnt_d      = smp_cnt_q;
        shadow_d       = shadow_q;
        asm_d          = asm_q;
        data_tx_d      = data_tx_q;
        tx_d           = 1'b0;
        ctrl_d         = ctrl_q;
        ctrl_valid_d   = 1'b0;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
`ifdef FRAME_DECODER_CHECKSUM_EN
        csum_bad_d     = csum_bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx && data_rx == SYNC_WORD) begin
                    byte_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = ST_CTRL;
                end
            end
            ST_CTRL: begin
                if (rx) begin
                    shadow_d[8*int'(byte_cnt_q) +: 8] = data_rx;
                    tmo_cnt_d = '0;
                    if (byte_cnt_q == BC_LAST) begin
                        byte_cnt_d = '0;
`ifdef FRAME_DECODER_CHECKSUM_EN
                        state_d    = ST_CSUM;
`else
                        state_d    = ST_CHECK;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TC_W'(1);
                end
            end
`ifdef FRAME_DECODER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx) begin
                    csum_bad_d = (data_rx != csum_exp);
                    tmo_cnt_d  = '0;
                    state_d    = ST_CHECK;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TC_W'(1);
                end
            end
`endif
            ST_CHECK: begin
`ifdef FRAME_DECODER_CHECKSUM_EN
                if (csum_bad_q) begin
                    tx_d      = 1'b1;
                    data_tx_d = NACK_WORD;
                    state_d   = ST_IDLE;
                end else begin
                    ctrl_d       = shadow_q;
                    ctrl_valid_d = 1'b1;
                    state_d      = ST_ACK;
                end
`else
                ctrl_d       = shadow_q;
                ctrl_valid_d = 1'b1;
                state_d      = ST_ACK;
`endif
            end
            ST_ACK: begin
                tx_d      = 1'b1;
                data_tx_d = ACK_WORD;
                smp_cnt_d = '0;
                asm_d     = '0;
                state_d   = ST_STREAM;
            end
            ST_STREAM: begin
                if (rx && data_rx == SYNC_WORD) begin
                    smp_cnt_d  = '0;
                    asm_d      = '0;
                    byte_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = ST_CTRL;
                end else if (rx) begin
                    asm_d = asm_shift[SW-1:0];
                    if (smp_cnt_q == SC_LAST) begin
                        sample_d       = asm_shift[SW-1:0];
                        sample_valid_d = 1'b1;
                        smp_cnt_d      = '0;
                    end else begin
                        smp_cnt_d = smp_cnt_q + SC_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            smp_cnt_q      <= '0;
            shadow_q       <= '0;
            asm_q          <= '0;
            data_tx_q      <= '0;
            tx_q           <= 1'b0;
            ctrl_q         <= '0;
            ctrl_valid_q   <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
`ifdef FRAME_DECODER_CHECKSUM_EN
            csum_bad_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            smp_cnt_q      <= smp_cnt_d;
            shadow_q       <= shadow_d;
            asm_q          <= asm_d;
            data_tx_q      <= data_tx_d;
            tx_q           <= tx_d;
            ctrl_q         <= ctrl_d;
            ctrl_valid_q   <= ctrl_valid_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
`ifdef FRAME_DECODER_CHECKSUM_EN
            csum_bad_q     <= csum_bad_d;
`endif
        end
    end

    assign data_tx      = data_tx_q;
    assign tx           = tx_q;
    assign ctrl         = ctrl_q;
    assign ctrl_valid   = ctrl_valid_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign in_stream    = (state_q == ST_STREAM);

endmodule

// File: tb/tb_frame_decoder.sv
// Directed scoreboard bench for frame_decoder (default parameters, either checksum build).
module tb_frame_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  data_rx;
    logic        rx;
    logic [7:0]  data_tx;
    logic        tx;
    logic [15:0] ctrl;
    logic        ctrl_valid;
    logic [15:0] sample;
    logic        sample_valid;
    logic        in_stream;

    frame_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .data_rx      (data_rx),
        .rx           (rx),
        .data_tx      (data_tx),
        .tx           (tx),
        .ctrl         (ctrl),
        .ctrl_valid   (ctrl_valid),
        .sample       (sample),
        .sample_valid (sample_valid),
        .in_stream    (in_stream)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hdr_cyc = 0;

    logic [15:0] exp_ctrl[$];
    logic [15:0] exp_sample[$];
    logic [7:0]  exp_tx[$];
    int          exp_lat[$];

    // Compare every output pulse of the latest edge against the scoreboard.
    task automatic mon();
        logic [15:0] e16;
        logic [7:0]  e8;
        int          lat;
        if (ctrl_valid === 1'b1) begin
            total++;
            assert (exp_ctrl.size() != 0) else begin
                bad++; $error("FAIL ctrl_valid_unexpected obs=%h exp=none", ctrl);
            end
            if (exp_ctrl.size() != 0) begin
                e16 = exp_ctrl.pop_front();
                total++;
                assert (ctrl === e16) else begin
                    bad++; $error("FAIL ctrl_value obs=%h exp=%h", ctrl, e16);
                end
            end
        end
        if (sample_valid === 1'b1) begin
            total++;
            assert (exp_sample.size() != 0) else begin
                bad++; $error("FAIL sample_valid_unexpected obs=%h exp=none", sample);
            end
            if (exp_sample.size() != 0) begin
                e16 = exp_sample.pop_front();
                total++;
                assert (sample === e16) else begin
                    bad++; $error("FAIL sample_value obs=%h exp=%h", sample, e16);
                end
            end
        end
        if (tx === 1'b1) begin
            total++;
            assert (exp_tx.size() != 0) else begin
                bad++; $error("FAIL tx_unexpected obs=%h exp=none", data_tx);
            end
            if (exp_tx.size() != 0) begin
                e8  = exp_tx.pop_front();
                lat = exp_lat.pop_front();
                total++;
                assert (data_tx === e8) else begin
                    bad++; $error("FAIL tx_data obs=%h exp=%h", data_tx, e8);
                end
                total++;
                assert ((cyc - last_hdr_cyc) === lat) else begin
                    bad++; $error("FAIL tx_latency obs=%0d exp=%0d", cyc - last_hdr_cyc, lat);
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic [7:0] d);
        rx      = r;
        data_rx = d;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mon();
    endtask

    task automatic byte_in(input logic [7:0] d);
        tick(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1, input int gap);
        byte_in(8'hFF);
        byte_in(b0);
        idle(gap);
        byte_in(b1);
`ifdef FRAME_DECODER_CHECKSUM_EN
        byte_in(b0 ^ b1);
`endif
        last_hdr_cyc = cyc;
    endtask

    task automatic expect_ack(input logic [15:0] c);
        exp_ctrl.push_back(c);
        exp_tx.push_back(8'hAA);
        exp_lat.push_back(2);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++; $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drained(input string tag);
        check(tag, 32'(exp_ctrl.size() + exp_sample.size() + exp_tx.size()), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        rx      = 1'b0;
        data_rx = 8'h00;
        @(negedge clk);
        tick(1'b1, 8'hFF);
        tick(1'b0, 8'h00);
        check("reset_outputs", {7'd0, data_tx, tx, ctrl, ctrl_valid, sample, sample_valid, in_stream}, 32'd0);
        rst = 1'b0;
        idle(2);
        check("idle_in_stream", {31'd0, in_stream}, 32'd0);

        // Basic header and ACK
        expect_ack(16'h3412);
        send_hdr(8'h12, 8'h34, 0);
        idle(3);
        check("hdr_ctrl", {16'd0, ctrl}, {16'd0, 16'h3412});
        check("ack_in_stream", {31'd0, in_stream}, 32'd1);
        check("data_tx_hold", {24'd0, data_tx}, {24'd0, 8'hAA});
        drained("hdr_drain");

        // Two samples
        byte_in(8'h01);
        exp_sample.push_back(16'h0102);
        byte_in(8'h02);
        byte_in(8'h03);
        exp_sample.push_back(16'h0304);
        byte_in(8'h04);
        idle(2);
        check("sample_hold", {16'd0, sample}, {16'd0, 16'h0304});
        drained("samples_drain");

        // Resync mid-sample
        byte_in(8'h01);
        expect_ack(16'h7856);
        byte_in(8'hFF);
        check("resync_in_stream", {31'd0, in_stream}, 32'd0);
        byte_in(8'h56);
        byte_in(8'h78);
`ifdef FRAME_DECODER_CHECKSUM_EN
        byte_in(8'h56 ^ 8'h78);
`endif
        last_hdr_cyc = cyc;
        idle(3);
        byte_in(8'h0A);
        exp_sample.push_back(16'h0A0B);
        byte_in(8'h0B);
        idle(1);
        check("resync_ctrl", {16'd0, ctrl}, {16'd0, 16'h7856});
        drained("resync_drain");

        // Gap of TIMEOUT-1 idle cycles is still accepted
        expect_ack(16'hBC9A);
        send_hdr(8'h9A, 8'hBC, 1023);
        idle(3);
        check("gap_ctrl", {16'd0, ctrl}, {16'd0, 16'hBC9A});
        drained("gap_drain");

        // TIMEOUT idle cycles abandon the header
        byte_in(8'hFF);
        byte_in(8'h12);
        idle(1024);
        byte_in(8'h34);
        byte_in(8'h34);
        idle(4);
        check("tmo_ctrl", {16'd0, ctrl}, {16'd0, 16'hBC9A});
        check("tmo_in_stream", {31'd0, in_stream}, 32'd0);
        drained("tmo_drain");
        expect_ack(16'h3412);
        send_hdr(8'h12, 8'h34, 0);
        idle(3);
        check("tmo_restart_ctrl", {16'd0, ctrl}, {16'd0, 16'h3412});
        drained("tmo_restart_drain");

`ifdef FRAME_DECODER_CHECKSUM_EN
        // Bad checksum: NACK one cycle after checksum byte, ctrl untouched
        exp_tx.push_back(8'h55);
        exp_lat.push_back(1);
        byte_in(8'hFF);
        byte_in(8'h56);
        byte_in(8'h78);
        byte_in(8'h00);
        last_hdr_cyc = cyc;
        idle(3);
        check("nack_ctrl", {16'd0, ctrl}, {16'd0, 16'h3412});
        check("nack_in_stream", {31'd0, in_stream}, 32'd0);
        byte_in(8'h01);
        byte_in(8'h02);
        idle(2);
        drained("nack_drain");
        expect_ack(16'h3412);
        send_hdr(8'h12, 8'h34, 0);
        idle(3);
        drained("post_nack_drain");
`endif

        // Reset mid-stream discards everything
        byte_in(8'h01);
        rst = 1'b1;
        tick(1'b0, 8'h00);
        rst = 1'b0;
        check("midrst_outputs", {7'd0, data_tx, tx, ctrl, ctrl_valid, sample, sample_valid, in_stream}, 32'd0);
        byte_in(8'h01);
        byte_in(8'h02);
        idle(2);
        check("midrst_sample", {16'd0, sample}, 32'd0);
        expect_ack(16'h3412);
        send_hdr(8'h12, 8'h34, 0);
        idle(3);
        byte_in(8'h05);
        exp_sample.push_back(16'h0506);
        byte_in(8'h06);
        idle(2);
        drained("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
